// File: rtl/map_tile_arbiter.sv
// Shares the single-port map tile BRAM between video pixel fetch and in-order collision queries.
// Define ARB_STATS_EN to add the stall_count_out / served_count_out statistics counters.
module map_tile_arbiter #(
  parameter int unsigned MAP_W      = 160,
  parameter int unsigned MAP_H      = 90,
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned RESP_DEPTH = 4,
  parameter logic [3:0]  OOB_TILE   = 4'd1,
  localparam int unsigned AW        = $clog2(MAP_W * MAP_H)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_in,
  input  logic [10:0]   hcount_in,
  input  logic [9:0]    vcount_in,
  input  logic          q_valid_in,
  output logic          q_ready_out,
  input  logic [7:0]    q_tilex_in,
  input  logic [6:0]    q_tiley_in,
  output logic          r_valid_out,
  input  logic          r_ready_in,
  output logic [3:0]    r_tile_out,
  output logic          r_oob_out,
  output logic [AW-1:0] bram_addr_out,
  input  logic [3:0]    bram_dout_in,
`ifdef ARB_STATS_EN
  output logic [15:0]   stall_count_out,
  output logic [15:0]   served_count_out,
`endif
  output logic [3:0]    video_tile_out
);

  localparam int unsigned PW = $clog2(RESP_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic          active;
  logic          q_oob;
  logic          accept;
  logic [AW-1:0] video_addr;
  logic [AW-1:0] query_addr;
  logic [CW-1:0] credit_used;

  logic          p1_valid_q, p1_oob_q;
  logic          p2_valid_q, p2_oob_q;

  logic [4:0]    fifo_mem_q [RESP_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] fifo_count_q;
  logic          push, pop;
  logic [3:0]    push_tile;

  always_comb begin
    active      = (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));
    q_oob       = (q_tilex_in >= 8'(MAP_W)) || (q_tiley_in >= 7'(MAP_H));
    video_addr  = AW'(hcount_in[10:3]) + AW'(vcount_in[9:3]) * AW'(MAP_W);
    query_addr  = AW'(q_tilex_in) + AW'(q_tiley_in) * AW'(MAP_W);
    // Entries still in the BRAM pipe hold a FIFO slot, so the FIFO can never overflow.
    credit_used = fifo_count_q + CW'(p1_valid_q) + CW'(p2_valid_q);
    q_ready_out = !rst_in && !active && (credit_used < CW'(RESP_DEPTH));
    accept      = q_valid_in && q_ready_out;
    // Out-of-map queries leave the BRAM on the video address.
    bram_addr_out = (accept && !q_oob) ? query_addr : video_addr;
  end

  assign video_tile_out = bram_dout_in;

  // Two-stage tag pipe tracks the BRAM read latency.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      p1_valid_q <= 1'b0;
      p1_oob_q   <= 1'b0;
      p2_valid_q <= 1'b0;
      p2_oob_q   <= 1'b0;
    end else begin
      p1_valid_q <= accept;
      p1_oob_q   <= accept && q_oob;
      p2_valid_q <= p1_valid_q;
      p2_oob_q   <= p1_oob_q;
    end
  end

  always_comb begin
    push        = p2_valid_q;
    push_tile   = p2_oob_q ? OOB_TILE : bram_dout_in;
    r_valid_out = (fifo_count_q != '0);
    pop         = r_valid_out && r_ready_in;
    {r_oob_out, r_tile_out} = fifo_mem_q[rd_ptr_q];
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < RESP_DEPTH; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= {p2_oob_q, push_tile};
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      fifo_count_q <= fifo_count_q + 1'b1;
      else if (pop && !push) fifo_count_q <= fifo_count_q - 1'b1;
    end
  end

  always @(posedge pixel_clk_in) begin
    if (!rst_in) assert (!(push && !pop && (fifo_count_q == CW'(RESP_DEPTH))));
  end

`ifdef ARB_STATS_EN
  logic [15:0] stall_q, served_q;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_q  <= '0;
      served_q <= '0;
    end else begin
      if (q_valid_in && !q_ready_out && (stall_q != 16'hFFFF)) stall_q <= stall_q + 1'b1;
      if (pop) served_q <= served_q + 1'b1;
    end
  end

  assign stall_count_out  = stall_q;
  assign served_count_out = served_q;
`endif

endmodule
